// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master RAM arbiter: bus command codes and
// the read-return phase encoding.
package mem_arbiter_pkg;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD0  = 2'b01,
        RD1  = 2'b10
    } retState_e;

    // Code 2'b11 is reserved and deliberately never counts as a request.
    function automatic logic isRequest(input logic [1:0] cmd);
        return (cmd == MEM_READ) || (cmd == MEM_WRITE);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of both master request/response ports plus the RAM port.
// The arbiter uses the slave view; the masters and RAM sit on the master view.
interface mem_arbiter_if #(
    parameter int AW = 9,
    parameter int DW = 16
);
    logic [1:0]    m0_cmd;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_wait;
    logic          m0_rvalid;

    logic [1:0]    m1_cmd;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_wait;
    logic          m1_rvalid;

    logic [DW-1:0] rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
    logic [DW-1:0] ram_dout;

    modport slave (
        input  m0_cmd, m0_addr, m0_wdata, m1_cmd, m1_addr, m1_wdata, ram_dout,
        output m0_wait, m0_rvalid, m1_wait, m1_rvalid, rdata,
        output ram_addr, ram_din, ram_we
    );

    modport master (
        output m0_cmd, m0_addr, m0_wdata, m1_cmd, m1_addr, m1_wdata, ram_dout,
        input  m0_wait, m0_rvalid, m1_wait, m1_rvalid, rdata,
        input  ram_addr, ram_din, ram_we
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant. On a tie the requester that was not granted
// most recently wins; the history bit resets to "master 1" so master 0 wins first.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic lastGnt_q;
    logic lastGnt_d;

    always_comb begin
        gnt_o     = 2'b00;
        lastGnt_d = lastGnt_q;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = lastGnt_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
        if (gnt_o != 2'b00) begin
            lastGnt_d = gnt_o[1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lastGnt_q <= 1'b1;
        end else begin
            lastGnt_q <= lastGnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous single-port RAM between two bus masters, granting at
// most one request per cycle and tagging the returning read data per master.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW = 9,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    logic [1:0]    req;
    logic [1:0]    gnt;
    logic [AW-1:0] addrMux;
    logic [DW-1:0] dinMux;
    logic          weMux;
    retState_e     state_q;
    retState_e     state_d;

    assign req[0] = isRequest(bus.m0_cmd);
    assign req[1] = isRequest(bus.m1_cmd);

    rr_arbiter2 u_rr (
        .clk   (clk),
        .reset (reset),
        .req_i (req),
        .gnt_o (gnt)
    );

    // A granted non-write is necessarily a read, which opens a return phase.
    always_comb begin
        addrMux = '0;
        dinMux  = '0;
        weMux   = 1'b0;
        state_d = IDLE;
        if (gnt[0]) begin
            addrMux = bus.m0_addr;
            if (bus.m0_cmd == MEM_WRITE) begin
                dinMux = bus.m0_wdata;
                weMux  = 1'b1;
            end else begin
                state_d = RD0;
            end
        end else if (gnt[1]) begin
            addrMux = bus.m1_addr;
            if (bus.m1_cmd == MEM_WRITE) begin
                dinMux = bus.m1_wdata;
                weMux  = 1'b1;
            end else begin
                state_d = RD1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.ram_addr  = addrMux;
    assign bus.ram_din   = dinMux;
    assign bus.ram_we    = weMux;
    assign bus.rdata     = bus.ram_dout;
    assign bus.m0_wait   = req[0] & ~gnt[0];
    assign bus.m1_wait   = req[1] & ~gnt[1];
    assign bus.m0_rvalid = (state_q == RD0);
    assign bus.m1_rvalid = (state_q == RD1);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle table plus hand-built sequences for
// reset, round-robin alternation and reset during a pending read.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    typedef struct {
        logic [1:0]  c0;
        logic [8:0]  a0;
        logic [15:0] d0;
        logic [1:0]  c1;
        logic [8:0]  a1;
        logic [15:0] d1;
        logic        we;
        logic [8:0]  addr;
        logic [15:0] din;
        logic        w0;
        logic        w1;
        logic        rv0;
        logic        rv1;
        logic [15:0] rd;
    } vec_t;

    logic clk;
    logic reset;
    int   testsRun;
    int   testsFailed;
    logic [15:0] mem [512];
    vec_t vecs [13];
    vec_t v;

    mem_arbiter_if #(.AW(9), .DW(16)) bus ();

    mem_arbiter #(.AW(9), .DW(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM model with one cycle read latency.
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] = bus.ram_din;
        bus.ram_dout <= mem[bus.ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t s);
        bus.m0_cmd   = s.c0;
        bus.m0_addr  = s.a0;
        bus.m0_wdata = s.d0;
        bus.m1_cmd   = s.c1;
        bus.m1_addr  = s.a1;
        bus.m1_wdata = s.d1;
    endtask

    task automatic checkOutput(input string tag, input vec_t e);
        check({tag, " ram_we"},    32'(bus.ram_we),    32'(e.we));
        check({tag, " ram_addr"},  32'(bus.ram_addr),  32'(e.addr));
        if (e.we) check({tag, " ram_din"}, 32'(bus.ram_din), 32'(e.din));
        check({tag, " m0_wait"},   32'(bus.m0_wait),   32'(e.w0));
        check({tag, " m1_wait"},   32'(bus.m1_wait),   32'(e.w1));
        check({tag, " m0_rvalid"}, 32'(bus.m0_rvalid), 32'(e.rv0));
        check({tag, " m1_rvalid"}, 32'(bus.m1_rvalid), 32'(e.rv1));
        if (e.rv0 || e.rv1) check({tag, " rdata"}, 32'(bus.rdata), 32'(e.rd));
    endtask

    // Drive one cycle's inputs just after the edge, compare on the falling edge.
    task automatic runCycle(input string tag, input vec_t s);
        @(posedge clk);
        #1;
        applyStimulus(s);
        @(negedge clk);
        checkOutput(tag, s);
    endtask

    function automatic vec_t mk(input logic [1:0] c0, input logic [8:0] a0, input logic [15:0] d0,
                                input logic [1:0] c1, input logic [8:0] a1, input logic [15:0] d1,
                                input logic we, input logic [8:0] addr, input logic [15:0] din,
                                input logic w0, input logic w1, input logic rv0, input logic rv1,
                                input logic [15:0] rd);
        vec_t r;
        r = '{c0, a0, d0, c1, a1, d1, we, addr, din, w0, w1, rv0, rv1, rd};
        return r;
    endfunction

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        for (int i = 0; i < 512; i++) mem[i] = 16'hC000 | 16'(i);

        // Table starts right after reset: first tie would go to m0.
        vecs[0]  = mk(MEM_WRITE, 9'h005, 16'hD005, MEM_NONE,  9'h000, 16'h0000, 1, 9'h005, 16'hD005, 0, 0, 0, 0, 16'h0000);
        vecs[1]  = mk(MEM_READ,  9'h005, 16'h0000, MEM_NONE,  9'h000, 16'h0000, 0, 9'h005, 16'h0000, 0, 0, 0, 0, 16'h0000);
        vecs[2]  = mk(MEM_NONE,  9'h000, 16'h0000, MEM_NONE,  9'h000, 16'h0000, 0, 9'h000, 16'h0000, 0, 0, 1, 0, 16'hD005);
        vecs[3]  = mk(MEM_READ,  9'h030, 16'h0000, MEM_WRITE, 9'h030, 16'h1234, 1, 9'h030, 16'h1234, 1, 0, 0, 0, 16'h0000);
        vecs[4]  = mk(MEM_READ,  9'h030, 16'h0000, MEM_NONE,  9'h000, 16'h0000, 0, 9'h030, 16'h0000, 0, 0, 0, 0, 16'h0000);
        vecs[5]  = mk(2'b11,     9'h1FF, 16'hFFFF, MEM_NONE,  9'h000, 16'h0000, 0, 9'h000, 16'h0000, 0, 0, 1, 0, 16'h1234);
        vecs[6]  = mk(2'b11,     9'h1FF, 16'hFFFF, MEM_NONE,  9'h000, 16'h0000, 0, 9'h000, 16'h0000, 0, 0, 0, 0, 16'h0000);
        vecs[7]  = mk(MEM_READ,  9'h010, 16'h0000, MEM_READ,  9'h020, 16'h0000, 0, 9'h020, 16'h0000, 1, 0, 0, 0, 16'h0000);
        vecs[8]  = mk(MEM_READ,  9'h010, 16'h0000, MEM_READ,  9'h020, 16'h0000, 0, 9'h010, 16'h0000, 0, 1, 0, 1, 16'hC020);
        vecs[9]  = mk(MEM_NONE,  9'h000, 16'h0000, MEM_WRITE, 9'h040, 16'hBEEF, 1, 9'h040, 16'hBEEF, 0, 0, 1, 0, 16'hC010);
        vecs[10] = mk(MEM_NONE,  9'h000, 16'h0000, MEM_READ,  9'h040, 16'h0000, 0, 9'h040, 16'h0000, 0, 0, 0, 0, 16'h0000);
        vecs[11] = mk(MEM_WRITE, 9'h041, 16'h1111, 2'b11,     9'h0AA, 16'h2222, 1, 9'h041, 16'h1111, 0, 0, 0, 1, 16'hBEEF);
        vecs[12] = mk(MEM_NONE,  9'h000, 16'h0000, MEM_NONE,  9'h000, 16'h0000, 0, 9'h000, 16'h0000, 0, 0, 0, 0, 16'h0000);

        reset = 1'b1;
        applyStimulus(vecs[12]);
        @(negedge clk);
        checkOutput("in_reset", vecs[12]);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 10; i++) runCycle($sformatf("idle%0d", i), vecs[12]);

        for (int i = 0; i < 13; i++) runCycle($sformatf("vec%0d", i), vecs[i]);

        // Both masters reading continuously from reset: m0, m1, m0, m1.
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            v = vecs[12];
            if (k < 4) begin
                v.c0 = MEM_READ; v.a0 = 9'h010;
                v.c1 = MEM_READ; v.a1 = 9'h020;
                v.addr = (k % 2 == 0) ? 9'h010 : 9'h020;
                v.w1 = (k % 2 == 0);
                v.w0 = (k % 2 == 1);
            end
            v.rv0 = (k >= 1) && ((k - 1) % 2 == 0);
            v.rv1 = (k >= 1) && ((k - 1) % 2 == 1);
            v.rd  = v.rv0 ? 16'hC010 : 16'hC020;
            runCycle($sformatf("alt%0d", k), v);
        end

        // Reset lands before the edge that would commit an m1 read; the m0
        // write beforehand leaves the priority pointing at m1 unless reset clears it.
        runCycle("pre_wr", mk(MEM_WRITE, 9'h060, 16'h0606, MEM_NONE, 9'h000, 16'h0000,
                              1, 9'h060, 16'h0606, 0, 0, 0, 0, 16'h0000));
        runCycle("rd_gnt", mk(MEM_NONE, 9'h000, 16'h0000, MEM_READ, 9'h050, 16'h0000,
                              0, 9'h050, 16'h0000, 0, 0, 0, 0, 16'h0000));
        #1;
        reset = 1'b1;
        applyStimulus(vecs[12]);
        @(negedge clk);
        checkOutput("rst_drop0", vecs[12]);
        @(negedge clk);
        checkOutput("rst_drop1", vecs[12]);
        #1;
        reset = 1'b0;
        runCycle("post_tie", mk(MEM_READ, 9'h070, 16'h0000, MEM_READ, 9'h071, 16'h0000,
                                0, 9'h070, 16'h0000, 0, 1, 0, 0, 16'h0000));
        runCycle("post_ret", mk(MEM_NONE, 9'h000, 16'h0000, MEM_NONE, 9'h000, 16'h0000,
                                0, 9'h000, 16'h0000, 0, 0, 1, 0, 16'hC070));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter sharing the single-port 16-bit instruction/data RAM between the CPU and a second bus master (program loader / DMA engine). It accepts each master's `mem_cmd`/address/write-data request, grants at most one per cycle using round-robin priority, drives the RAM port, and returns read data with a per-master valid strobe. A losing master is held off with a `wait` signal until it is granted.

## Interface
Parameters:
- `AW`, 9, address width (matches `mem_addr`)
- `DW`, 16, data width

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high
- `m0_cmd`  in  2  master 0 (CPU) command: `00` none, `01` read, `10` write, `11` treated as none
- `m0_addr`  in  AW  master 0 address
- `m0_wdata`  in  DW  master 0 write data
- `m0_wait`  out  1  master 0 request present but not granted this cycle
- `m0_rvalid`  out  1  master 0 read data valid on `rdata`
- `m1_cmd`, `m1_addr`, `m1_wdata`, `m1_wait`, `m1_rvalid`: same as master 0, for master 1
- `rdata`  out  DW  shared read-data return (equals `ram_dout`)
- `ram_addr`  out  AW  RAM address
- `ram_din`  out  DW  RAM write data
- `ram_we`  out  1  RAM write enable
- `ram_dout`  in  DW  RAM synchronous read data (1-cycle latency)

## Operation
- Request: `mX_cmd` is `01` or `10`. `11` and `00` are ignored and never granted.
- Arbitration (combinational each cycle):
  - If only one master requests, it wins.
  - If both request, the master not granted most recently wins.
  - Priority register `last_gnt` updates on every grant. Reset value selects master 0 to win the first tie.
- Winner drives `ram_addr`. On a write, it also drives `ram_din` and sets `ram_we=1`.
- With no grant: `ram_we=0` and `ram_addr` holds 0.
- Loser gets `mX_wait=1`. It must hold cmd, addr and wdata stable until `wait` drops. The arbiter does not latch requests.
- Read: the grant cycle drives the address. `mX_rvalid` is registered and pulses for exactly one cycle on the following cycle, when `rdata = ram_dout` holds the data.
- Write: completes at the grant-cycle edge. No response strobe.
- Back-to-back grants are allowed every cycle. This includes read-then-read, with reads pipelined at one per cycle.
- Read-after-write to the same address by either master in the next cycle returns the new data.
- `m0_rvalid` and `m1_rvalid` are never both high.
- State machine tracks the read-return phase: IDLE, RD0 (return to m0 pending), RD1 (return to m1 pending). Transitions are taken each cycle from the current grant:
  - read grant to m0 → RD0
  - read grant to m1 → RD1
  - otherwise → IDLE
  - `m0_rvalid = (state==RD0)`, `m1_rvalid = (state==RD1)`

## Timing
- Reset (asynchronous): state=IDLE, `last_gnt` = master 1, `m0_rvalid = m1_rvalid = 0`.
- Combinational outputs (`ram_*`, `wait`) follow inputs. With no request they are 0 during reset.
- Grant decision and RAM drive: same cycle as the request. Read data latency: 1 cycle after grant.
- Reset asserted mid-read: the pending `rvalid` is dropped and never issued. Masters re-issue after reset.
- Both masters continuously requesting: grants alternate m0, m1, m0, ... Worst-case wait is 1 cycle.
- Simultaneous read by one master and write by the other: the tie resolves by `last_gnt` only. Command type does not affect priority.

## Structure
- Shared package holds:
  - command constants `MEM_NONE=2'b00`, `MEM_READ=2'b01`, `MEM_WRITE=2'b10`, also used by the CPU state machine
  - return-phase state encoding IDLE/RD0/RD1
- One natural sub-module: `rr_arbiter2` (2-input round-robin grant with `last_gnt` register). Datapath muxing and the return FSM stay in the top module.

## Test plan
- Reset then idle: all `cmd=00` → `ram_we=0`, both `wait=0`, both `rvalid=0` for 10 cycles.
- m0 write addr 9'h005 data 16'hD005, next cycle m0 read 9'h005 → `ram_we=1` in cycle 1, `m0_rvalid=1` and `rdata=16'hD005` in cycle 3.
- Both masters read (m0 addr 9'h010, m1 addr 9'h020) held 4 cycles from reset:
  - grants go m0, m1, m0, m1
  - `m1_wait=1` in cycle 1, `m0_wait=1` in cycle 2
  - rvalids alternate one cycle later with matching RAM contents
- m1 writes 16'h1234 to 9'h030 while m0 reads 9'h030 in the same cycle, with `last_gnt` = m0:
  - m1 wins, m0 waits 1 cycle
  - m0 then reads 16'h1234
- Illegal `m0_cmd=11` with m1 idle → no grant, `ram_we=0`, `m0_wait=0`, no rvalid.
- m1 read granted, `reset` asserted in the next cycle before the edge → `m1_rvalid` stays 0. After release, state=IDLE and the first tie goes to m0.
